wb_arbiter: RTL
===============

WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 8'd255, sets the slave cycles to wait for s_ack_i before forced termination.
REQ-002 clk  input  1  single system clock, all state on posedge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 mN_adr_i (N=0,1)  input  7  master N CSR address.
REQ-005 mN_dat_i  input  8  master N write data.
REQ-006 mN_we_i  input  1  master N write enable, sampled with stb.
REQ-007 mN_stb_i  input  1  master N strobe; may be a one-cycle pulse.
REQ-008 mN_cyc_i  input  1  master N cycle; held until ack.
REQ-009 mN_ack_o  output  1  one-cycle acknowledge to master N.
REQ-010 mN_dat_o  output  8  read data to master N, valid while mN_ack_o high.
REQ-011 s_adr_o / s_dat_o / s_we_o  output  7/8/1  shared slave address, write data, write enable.
REQ-012 s_stb_o  output  1  one-cycle slave strobe.
REQ-013 s_cyc_o  output  1  slave cycle, high from strobe until ack or timeout.
REQ-014 s_dat_i  input  8  slave read data.
REQ-015 s_ack_i  input  1  slave acknowledge.
REQ-016 timeout_o  output  1  one-cycle pulse on forced termination.

Function
REQ-017 Each master has a pending register; posedge with mN_cyc_i&mN_stb_i and no pending/in-flight transaction for N sets pending and captures adr/dat/we.
REQ-018 Strobe from a master whose transaction is pending or in flight is ignored; pending is cleared if mN_cyc_i drops before grant.
REQ-019 FSM states: ST_IDLE, ST_STB, ST_WAIT; all outputs registered.
REQ-020 ST_IDLE with any pending: grant one, clear its pending, load s_adr_o/s_dat_o/s_we_o, go ST_STB.
REQ-021 Round-robin: both pending -> grant master not granted last; last-grant resets to 1 (master 0 wins first tie).
REQ-022 ST_STB: s_cyc_o=1, s_stb_o=1 for exactly one cycle, then ST_WAIT with s_cyc_o=1, s_stb_o=0.
REQ-023 Latency: master strobe sampled at edge k, arbiter idle -> s_stb_o high in cycle after edge k+1.
REQ-024 s_ack_i sampled high in ST_STB or ST_WAIT -> next cycle: granted mN_ack_o=1, mN_dat_o=s_dat_i, s_cyc_o=0, state ST_IDLE.
REQ-025 Non-granted master's ack_o stays 0; its dat_o holds previous value.
REQ-026 8-bit timeout counter clears on grant, increments each cycle in ST_STB/ST_WAIT; reaching TIMEOUT without ack -> granted ack_o=1, dat_o=8'hFF, timeout_o=1, s_cyc_o=0, ST_IDLE.
REQ-027 s_ack_i outside ST_STB/ST_WAIT is ignored.
REQ-028 Next grant no earlier than one cycle after ack; back-to-back transactions have one ST_IDLE cycle between.

Reset
REQ-029 rst high asynchronously forces ST_IDLE, pending=0, last-grant=1, counter=0, all outputs 0 incl. data/address, even mid-transaction.
REQ-030 In-flight transaction at reset is discarded; no ack issued.

Structure
REQ-031 Package wb_arb_pkg holds ADR_W=7, DAT_W=8, state encoding, TIMEOUT_DATA=8'hFF.
REQ-032 Sub-module wb_req_latch (pending flag + adr/dat/we capture), instantiated once per master.

Verification
REQ-033 m0 read adr 7'h05, slave acks 3 cycles after s_stb_o with 8'hA5 -> s_stb_o 2 edges after m0 stb, m0_ack_o one cycle, m0_dat_o=8'hA5, m1_ack_o=0.
REQ-034 m0 and m1 strobe same cycle after reset -> m0 served first, then m1; second pair -> m1 first.
REQ-035 m1 write adr 7'h10 data 8'h3C while m0 in flight -> m1 request kept, issued after m0 ack with s_we_o=1, s_dat_o=8'h3C.
REQ-036 Slave never acks, TIMEOUT=8 -> after 8 cycles m0_ack_o=1, m0_dat_o=8'hFF, timeout_o one pulse, s_cyc_o=0.
REQ-037 rst asserted during ST_WAIT -> outputs 0 immediately; late s_ack_i produces no ack; next request served normally.

Source files
------------

// File: rtl/wb_arb_pkg.sv
// Shared definitions for the two-master Wishbone CSR arbiter.
//   ADR_W / DAT_W : CSR address and data widths
//   TIMEOUT_DATA  : read data returned to a master when the slave never acks
//   state_e       : arbiter FSM encoding
//   req_t         : captured master request (address, write data, write enable)
package wb_arb_pkg;
  localparam int ADR_W = 7;
  localparam int DAT_W = 8;
  localparam logic [DAT_W-1:0] TIMEOUT_DATA = 8'hFF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_STB  = 2'd1,
    ST_WAIT = 2'd2
  } state_e;

  typedef struct packed {
    logic [ADR_W-1:0] adr;
    logic [DAT_W-1:0] dat;
    logic             we;
  } req_t;
endpackage

// File: rtl/wb_req_latch.sv
// Per-master request holder: pending flag plus captured adr/dat/we.
//   clk, rst          : clock, async active-high reset
//   cyc_i, stb_i      : master cycle / strobe (strobe may be a single pulse)
//   adr_i, dat_i, we_i: master request fields, captured with the strobe
//   busy_i            : this master's transaction is in flight or being acked
//   grant_i           : arbiter is taking the request this cycle
//   pend_o, req_o     : pending flag and captured request
module wb_req_latch
  import wb_arb_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             cyc_i,
  input  logic             stb_i,
  input  logic [ADR_W-1:0] adr_i,
  input  logic [DAT_W-1:0] dat_i,
  input  logic             we_i,
  input  logic             busy_i,
  input  logic             grant_i,
  output logic             pend_o,
  output req_t             req_o
);
  logic pend_q, pend_d;
  req_t req_q, req_d;

  always_comb begin
    pend_d = pend_q;
    req_d  = req_q;
    // Grant consumes the request; a master abandoning its cycle withdraws it.
    if (grant_i || !cyc_i) begin
      pend_d = 1'b0;
    end else if (stb_i && !pend_q && !busy_i) begin
      pend_d = 1'b1;
      req_d  = '{adr: adr_i, dat: dat_i, we: we_i};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_q <= 1'b0;
      req_q  <= '0;
    end else begin
      pend_q <= pend_d;
      req_q  <= req_d;
    end
  end

  assign pend_o = pend_q;
  assign req_o  = req_q;
endmodule

// File: rtl/wb_arbiter.sv
// Two-master to one-slave Wishbone CSR arbiter with round-robin tie break
// and a slave ack timeout. All outputs are registered.
//   mN_*_i     : master N request (adr, dat, we, stb, cyc)
//   mN_ack_o   : one-cycle ack to master N; mN_dat_o valid with it
//   s_*_o      : shared slave request; s_stb_o is a one-cycle strobe
//   s_dat_i/s_ack_i : slave response
//   timeout_o  : one-cycle pulse when a transaction is force-terminated
module wb_arbiter
  import wb_arb_pkg::*;
#(
  parameter logic [7:0] TIMEOUT = 8'd255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [ADR_W-1:0] m0_adr_i,
  input  logic [DAT_W-1:0] m0_dat_i,
  input  logic             m0_we_i,
  input  logic             m0_stb_i,
  input  logic             m0_cyc_i,
  output logic             m0_ack_o,
  output logic [DAT_W-1:0] m0_dat_o,
  input  logic [ADR_W-1:0] m1_adr_i,
  input  logic [DAT_W-1:0] m1_dat_i,
  input  logic             m1_we_i,
  input  logic             m1_stb_i,
  input  logic             m1_cyc_i,
  output logic             m1_ack_o,
  output logic [DAT_W-1:0] m1_dat_o,
  output logic [ADR_W-1:0] s_adr_o,
  output logic [DAT_W-1:0] s_dat_o,
  output logic             s_we_o,
  output logic             s_stb_o,
  output logic             s_cyc_o,
  input  logic [DAT_W-1:0] s_dat_i,
  input  logic             s_ack_i,
  output logic             timeout_o
);
  state_e state_q, state_d;
  logic             gnt_q, gnt_d;
  logic             last_q, last_d;
  logic [7:0]       cnt_q, cnt_d;
  logic [ADR_W-1:0] s_adr_q, s_adr_d;
  logic [DAT_W-1:0] s_dat_q, s_dat_d;
  logic             s_we_q, s_we_d, s_stb_q, s_stb_d, s_cyc_q, s_cyc_d;
  logic [1:0]       ack_q, ack_d;
  logic [1:0][DAT_W-1:0] mdat_q, mdat_d;
  logic             to_q, to_d;

  logic [1:0] cyc_v, stb_v, we_v, busy_v, pend_raw, pend_v, grant;
  logic [1:0][ADR_W-1:0] adr_v;
  logic [1:0][DAT_W-1:0] dat_v;
  req_t req_v [2];
  logic sel;

  assign cyc_v = {m1_cyc_i, m0_cyc_i};
  assign stb_v = {m1_stb_i, m0_stb_i};
  assign we_v  = {m1_we_i, m0_we_i};
  assign adr_v = {m1_adr_i, m0_adr_i};
  assign dat_v = {m1_dat_i, m0_dat_i};

  for (genvar i = 0; i < 2; i++) begin : g_m
    // The ack cycle still counts as busy so a master holding stb until it
    // sees ack cannot re-queue the same transaction.
    assign busy_v[i] = ((state_q != ST_IDLE) && (gnt_q == 1'(i))) || ack_q[i];
    wb_req_latch u_latch (
      .clk(clk), .rst(rst), .cyc_i(cyc_v[i]), .stb_i(stb_v[i]),
      .adr_i(adr_v[i]), .dat_i(dat_v[i]), .we_i(we_v[i]),
      .busy_i(busy_v[i]), .grant_i(grant[i]),
      .pend_o(pend_raw[i]), .req_o(req_v[i])
    );
  end

  // A request whose cycle was dropped this cycle is not granted.
  assign pend_v = pend_raw & cyc_v;

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    s_adr_d = s_adr_q;
    s_dat_d = s_dat_q;
    s_we_d  = s_we_q;
    s_stb_d = 1'b0;
    s_cyc_d = s_cyc_q;
    ack_d   = '0;
    mdat_d  = mdat_q;
    to_d    = 1'b0;
    grant   = '0;
    sel     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (|pend_v) begin
          // The priority pointer only moves on a contested grant, so the
          // loser of one tie wins the next one.
          if (&pend_v) begin
            sel    = ~last_q;
            last_d = sel;
          end else begin
            sel = pend_v[1];
          end
          grant[sel] = 1'b1;
          gnt_d   = sel;
          cnt_d   = '0;
          s_adr_d = req_v[sel].adr;
          s_dat_d = req_v[sel].dat;
          s_we_d  = req_v[sel].we;
          s_stb_d = 1'b1;
          s_cyc_d = 1'b1;
          state_d = ST_STB;
        end
      end
      ST_STB, ST_WAIT: begin
        if (s_ack_i) begin
          ack_d[gnt_q]  = 1'b1;
          mdat_d[gnt_q] = s_dat_i;
          s_cyc_d = 1'b0;
          state_d = ST_IDLE;
        end else if (cnt_q == TIMEOUT - 8'd1) begin
          ack_d[gnt_q]  = 1'b1;
          mdat_d[gnt_q] = TIMEOUT_DATA;
          to_d    = 1'b1;
          s_cyc_d = 1'b0;
          state_d = ST_IDLE;
        end else begin
          cnt_d   = cnt_q + 8'd1;
          state_d = ST_WAIT;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      gnt_q   <= 1'b0;
      last_q  <= 1'b1;
      cnt_q   <= '0;
      s_adr_q <= '0;
      s_dat_q <= '0;
      s_we_q  <= 1'b0;
      s_stb_q <= 1'b0;
      s_cyc_q <= 1'b0;
      ack_q   <= '0;
      mdat_q  <= '0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      s_adr_q <= s_adr_d;
      s_dat_q <= s_dat_d;
      s_we_q  <= s_we_d;
      s_stb_q <= s_stb_d;
      s_cyc_q <= s_cyc_d;
      ack_q   <= ack_d;
      mdat_q  <= mdat_d;
      to_q    <= to_d;
    end
  end

  assign m0_ack_o  = ack_q[0];
  assign m1_ack_o  = ack_q[1];
  assign m0_dat_o  = mdat_q[0];
  assign m1_dat_o  = mdat_q[1];
  assign s_adr_o   = s_adr_q;
  assign s_dat_o   = s_dat_q;
  assign s_we_o    = s_we_q;
  assign s_stb_o   = s_stb_q;
  assign s_cyc_o   = s_cyc_q;
  assign timeout_o = to_q;
endmodule
